// File: rtl/sprite_anim_engine_if.sv
// rtl/sprite_anim_engine_if.sv - sprite ROM address/data port
// master drives the ROM address, slave returns combinational pixel data.
interface sprite_anim_engine_if;
   logic [2:0]  rom_state;
   logic [2:0]  rom_frame;
   logic [12:0] rom_addr;
   logic [15:0] rom_colour;

   modport master (output rom_state, rom_frame, rom_addr, input rom_colour);
   modport slave  (input rom_state, rom_frame, rom_addr, output rom_colour);
endinterface

// File: rtl/sprite_anim_engine.sv
// rtl/sprite_anim_engine.sv - sprite frame sequencer with a two-stage pixel/ROM pipeline
// Optional green tint on modify_col when SPRITE_TINT_EN is defined.
module sprite_anim_engine #(
   parameter int          NUM_STATES    = 8,
   parameter int          TICK_DIV      = 12_500_000,
   parameter logic [31:0] STATE_FRAMES  = 32'h33333333,
   parameter logic [7:0]  STATE_ONESHOT = 8'b00010110,
   parameter int          SCREEN_W      = 96,
   parameter int          SCREEN_H      = 64,
   parameter logic [15:0] TRANSPARENT   = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            character_state,
   input  logic                  mirror,
   input  logic                  modify_col,
   input  logic [6:0]            x,
   input  logic [6:0]            y,
   input  logic [12:0]           pixel_index,
   sprite_anim_engine_if.master  rom,
   output logic [15:0]           oled_colour,
   output logic [2:0]            cur_frame,
   output logic                  anim_done
);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic signed [15:0] W_S    = 16'(SCREEN_W);
   localparam logic signed [15:0] H_S    = 16'(SCREEN_H);
   localparam logic signed [15:0] HALF_W = 16'(SCREEN_W / 2);
   localparam logic signed [15:0] HALF_H = 16'(SCREEN_H / 2);

   typedef enum logic {ANIM_RUN, ANIM_HELD} anim_phase_t;

   anim_phase_t      phase_q, phase_d;
   logic [2:0]       st_q, st_d, frame_q, frame_d;
   logic [2:0]       req_state, last, step_frame;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick, oneshot, done_d;

   // Frame counts of 0 behave as 1, anything above 8 saturates at 8.
   function automatic logic [2:0] last_frame(input logic [2:0] s);
      logic [3:0] n;
      n = STATE_FRAMES[{s, 2'b00} +: 4];
      if (n == 4'd0)
         n = 4'd1;
      else if (n > 4'd8)
         n = 4'd8;
      return 3'(n - 4'd1);
   endfunction

   assign req_state  = (int'(character_state) < NUM_STATES) ? character_state : 3'd0;
   assign tick       = (cnt_q == CNT_LAST);
   assign oneshot    = STATE_ONESHOT[st_q];
   assign last       = last_frame(st_q);
   assign step_frame = (frame_q < last) ? frame_q + 3'd1 : frame_q;
   assign cur_frame  = frame_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= 3'd0;
         frame_q   <= 3'd0;
         cnt_q     <= '0;
         phase_q   <= ANIM_RUN;
         anim_done <= 1'b0;
      end else begin
         st_q      <= st_d;
         frame_q   <= frame_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         anim_done <= done_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      frame_d = frame_q;
      cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
      phase_d = phase_q;
      done_d  = 1'b0;
      if (req_state != st_q) begin
         st_d    = req_state;
         frame_d = 3'd0;
         cnt_d   = '0;
         phase_d = ANIM_RUN;
      end else if (tick) begin
         if (!oneshot)
            frame_d = (frame_q == last) ? 3'd0 : frame_q + 3'd1;
         else if (phase_q == ANIM_RUN) begin
            frame_d = step_frame;
            if (step_frame == last) begin
               phase_d = ANIM_HELD;
               done_d  = 1'b1;
            end
         end
      end
   end

   logic [12:0]        px, py, addr;
   logic signed [15:0] px_s, py_s, x_s, y_s, sc, sr;
   logic               oob, oob_q;
   logic [15:0]        pix_colour;

   assign px   = pixel_index % 13'(SCREEN_W);
   assign py   = pixel_index / 13'(SCREEN_W);
   assign px_s = {3'b000, px};
   assign py_s = {3'b000, py};
   assign x_s  = {9'd0, x};
   assign y_s  = {9'd0, y};
   assign sc   = mirror ? (x_s + HALF_W - px_s) : (px_s - x_s + HALF_W);
   assign sr   = py_s - y_s + HALF_H;
   assign oob  = (sc < 16'sd0) || (sc > W_S - 16'sd1) || (sr < 16'sd0) || (sr > H_S - 16'sd1);
   assign addr = 13'(sr * W_S + sc);

   // State and frame travel with the pixel so one pixel never mixes frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom.rom_addr  <= 13'd0;
         rom.rom_state <= 3'd0;
         rom.rom_frame <= 3'd0;
         oob_q         <= 1'b1;
      end else begin
         rom.rom_addr  <= oob ? 13'd0 : addr;
         rom.rom_state <= st_q;
         rom.rom_frame <= frame_q;
         oob_q         <= oob;
      end
   end

`ifdef SPRITE_TINT_EN
   logic tint_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tint_q <= 1'b0;
      else
         tint_q <= modify_col;
   end

   assign pix_colour = (tint_q && rom.rom_colour != TRANSPARENT)
                     ? {rom.rom_colour[15:11], 1'b0, rom.rom_colour[10:6], rom.rom_colour[4:0]}
                     : rom.rom_colour;
`else
   logic unused_modify_col;
   assign unused_modify_col = modify_col;
   assign pix_colour = rom.rom_colour;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         oled_colour <= TRANSPARENT;
      else
         oled_colour <= oob_q ? TRANSPARENT : pix_colour;
   end
endmodule

// File: doc/sprite_anim_engine.md
SPRITE_ANIM_ENGINE -- requirements
Module: sprite_anim_engine

Interface
REQ-001 The block SHALL have parameter NUM_STATES, default 8, meaning the number of animation states (1..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 12_500_000, meaning clk cycles per animation frame step (8 Hz at 100 MHz).
REQ-003 The block SHALL have parameter STATE_FRAMES, default 32'h33333333, meaning a packed 4-bit frame count per state, with state s at bits [4s+3:4s].
REQ-004 The block SHALL have parameter STATE_ONESHOT, default 8'b00010110, meaning one bit per state: 1 = one-shot, 0 = loop.
REQ-005 The block SHALL have parameters SCREEN_W, default 96, and SCREEN_H, default 64, meaning the sprite frame dimensions in pixels.
REQ-006 The block SHALL have parameter TRANSPARENT, default 16'hFFFF, meaning the background colour.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port character_state, input, 3 bits: the requested animation state.
REQ-010 The block SHALL have port mirror, input, 1 bit: horizontal flip.
REQ-011 The block SHALL have port modify_col, input, 1 bit: tint request.
REQ-012 The block SHALL have ports x and y, inputs, 7 bits each: the sprite centre in screen coordinates.
REQ-013 The block SHALL have port pixel_index, input, 13 bits: the screen pixel, equal to row*SCREEN_W+col.
REQ-014 The block SHALL have ports rom_state (output, 3 bits), rom_frame (output, 3 bits) and rom_addr (output, 13 bits): the sprite ROM address.
REQ-015 The block SHALL have port rom_colour, input, 16 bits: combinational ROM data for the current rom_* address.
REQ-016 The block SHALL have port oled_colour, output, 16 bits: the RGB565 pixel.
REQ-017 The block SHALL have port cur_frame, output, 3 bits: the displayed frame number.
REQ-018 The block SHALL have port anim_done, output, 1 bit: a one-cycle pulse when a one-shot animation completes.

Function
REQ-019 The tick counter SHALL count 0..TICK_DIV-1 and SHALL assert a one-cycle internal tick when it wraps to 0.
REQ-020 character_state values >= NUM_STATES SHALL be treated as state 0.
REQ-021 A STATE_FRAMES entry of 0 SHALL be treated as 1; entries above 8 SHALL be treated as 8.
REQ-022 When the requested state differs from the registered state, the next edge SHALL load the new state, set the frame to 0, clear the tick counter and clear the one-shot-done flag.
REQ-023 A state change SHALL take priority over a tick arriving in the same cycle.
REQ-024 On a tick in a loop state, the frame SHALL step as frame = (frame == N-1) ? 0 : frame+1.
REQ-025 On a tick in a one-shot state with frame < N-1, the frame SHALL increment.
REQ-026 In a one-shot state, the cycle in which the frame reaches N-1 SHALL pulse anim_done for exactly one cycle.
REQ-027 In a one-shot state, the frame SHALL then hold at N-1 with no further pulses until a state change.
REQ-028 When N = 1 in a one-shot state, anim_done SHALL pulse on the first tick after entry.
REQ-029 Column and row SHALL be computed as px = pixel_index % SCREEN_W and py = pixel_index / SCREEN_W.
REQ-030 The sprite column SHALL be sc = px - x + SCREEN_W/2 when mirror = 0, and sc = x + SCREEN_W/2 - px when mirror = 1.
REQ-031 The sprite row SHALL be sr = py - y + SCREEN_H/2, with all arithmetic signed and at least 9 bits wide.
REQ-032 Stage 1 SHALL register rom_addr = sr*SCREEN_W+sc, rom_state, rom_frame and an out-of-bounds flag (sc or sr outside [0, dimension-1]).
REQ-033 When the out-of-bounds flag is set, rom_addr SHALL be 0.
REQ-034 Stage 2 SHALL register oled_colour from rom_colour, or TRANSPARENT when the out-of-bounds flag is set.
REQ-035 The total latency from pixel_index to oled_colour SHALL be 2 cycles, with a new pixel accepted every cycle.
REQ-036 rom_state and rom_frame SHALL be sampled together with pixel_index, so that no pixel mixes frames.

Reset
REQ-037 While rst_n = 0, the state register, frame, tick counter, done flag, anim_done, cur_frame, rom_state, rom_frame and rom_addr SHALL be 0.
REQ-038 While rst_n = 0, the out-of-bounds flag SHALL be 1 and oled_colour SHALL be TRANSPARENT.
REQ-039 A reset asserted mid-animation SHALL abort the animation without pulsing anim_done.
REQ-040 After rst_n deasserts, the first tick SHALL occur TICK_DIV cycles later.

Configuration
REQ-041 With macro SPRITE_TINT_EN defined, when modify_col = 1 and the colour is not TRANSPARENT, stage 2 SHALL output green bits [10:5] shifted right by 1, with other bits unchanged.
REQ-042 Without SPRITE_TINT_EN, modify_col SHALL be ignored and oled_colour SHALL pass rom_colour unchanged.

Verification
REQ-043 Bench with TICK_DIV = 4 and state 0 (loop, N = 3) held: cur_frame SHALL follow 0,1,2,0,1 at ticks, with anim_done never asserted.
REQ-044 Bench with state 1 (one-shot, N = 3): frames SHALL be 0,1,2,2,2 and anim_done SHALL pulse once, in the cycle frame becomes 2.
REQ-045 Bench switching state 0->2 in the same cycle as a tick: cur_frame SHALL be 0, the tick counter SHALL be 0 and the state SHALL be 2 on the next edge.
REQ-046 Bench with x=48, y=32, mirror=0, pixel_index=100: rom_addr SHALL be 100 after 1 cycle; with mirror=1, rom_addr SHALL be 188 (sc=92, sr=1).
REQ-047 Bench with x=10, pixel_index=95 (sc=133): oled_colour SHALL be 16'hFFFF 2 cycles later, regardless of rom_colour.
REQ-048 Bench with SPRITE_TINT_EN defined, modify_col=1 and rom_colour=16'h07E0: oled_colour SHALL be 16'h03E0; with rst_n pulsed low mid-frame, all outputs SHALL return to their reset values immediately.
